// File: rtl/psum_acc_buffer.sv
// Multi-lane partial-sum FIFO: vectors open a tail entry or accumulate (saturating)
// into it; only closed entries are offered downstream over valid/ready.
module psum_acc_buffer #(
  parameter int CH    = 10,
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*DW-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH*DW-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         sat_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [DW-1:0] LANE_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] LANE_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [CH*DW-1:0] mem_q [DEPTH];
  logic [CH*DW-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] closed_q, closed_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sat_q, sat_d;

  logic [PW-1:0]    newest;
  logic             tail_open;
  logic             wr_fire;
  logic             rd_fire;
  logic             push;
  logic [CH*DW-1:0] acc_data;
  logic             acc_sat;
  logic [DW:0]      lane_r;

  // Returns {clamped, value}; the sum is formed one bit wider so overflow is visible.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      return {1'b1, (s[DW] ? LANE_MIN : LANE_MAX)};
    end
    return {1'b0, s[DW-1:0]};
  endfunction

  // tail_q is the next free slot, so the newest entry sits one behind it.
  assign newest    = tail_q - PW'(1);
  assign tail_open = (count_q != '0) && !closed_q[newest];
  assign in_ready  = tail_open || (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0) && closed_q[head_q];
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign count     = count_q;
  assign sat_flag  = sat_q;

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign push    = wr_fire && !tail_open;

  always_comb begin
    acc_data = '0;
    acc_sat  = 1'b0;
    lane_r   = '0;
    for (int i = 0; i < CH; i++) begin
      lane_r = sat_add(mem_q[newest][i*DW +: DW], in_data[i*DW +: DW]);
      acc_data[i*DW +: DW] = lane_r[DW-1:0];
      acc_sat = acc_sat | lane_r[DW];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    closed_d = closed_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sat_d    = sat_q;
    if (clr) begin
      closed_d = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      sat_d    = 1'b0;
    end else begin
      if (wr_fire) begin
        if (tail_open) begin
          mem_d[newest]    = acc_data;
          closed_d[newest] = in_last;
          if (acc_sat) begin
            sat_d = 1'b1;
          end
        end else begin
          mem_d[tail_q]    = in_data;
          closed_d[tail_q] = in_last;
          tail_d           = tail_q + PW'(1);
        end
      end
      if (rd_fire) begin
        head_d = head_q + PW'(1);
      end
      case ({push, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      closed_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      closed_q <= closed_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  // Storage needs no reset: nothing reads it until an entry has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Bench for psum_acc_buffer: directed vector table, hand sequences for multi-cycle
// corners, then random traffic against a queue-based reference model.
module tb_psum_acc_buffer;
  localparam int CH    = 10;
  localparam int DW    = 20;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int LMAX  = (1 << (DW-1)) - 1;
  localparam int LMIN  = -(1 << (DW-1));

  logic clk = 1'b0;
  logic rst, clr, in_valid, in_ready, in_last, out_valid, out_ready, sat_flag;
  logic [CH*DW-1:0] in_data, out_data;
  logic [CW-1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  psum_acc_buffer #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit c, v, l, r;
    int val, val9;
    int e_cnt;
    bit e_ov, e_ir, e_sat;
    int e_l0, e_l9;
  } vec_rec_t;

  typedef logic signed [31:0] lane_t;
  typedef lane_t [CH-1:0] mvec_t;

  mvec_t mdata[$];
  bit    mclosed[$];
  bit    msat;

  function automatic int lane(input logic [CH*DW-1:0] v, input int i);
    logic [DW-1:0] x;
    x = v[i*DW +: DW];
    return int'($signed(x));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c, input bit v, input bit l, input bit r, input int val, input int val9);
    clr = c; in_valid = v; in_last = l; out_ready = r;
    for (int i = 0; i < CH; i++) begin
      in_data[i*DW +: DW] = (i == CH-1) ? val9[DW-1:0] : val[DW-1:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  function automatic int clamp(input int s);
    if (s > LMAX) return LMAX;
    if (s < LMIN) return LMIN;
    return s;
  endfunction

  // One cycle of the reference model: compare outputs for the current state,
  // then advance the model with the inputs currently driven.
  task automatic model_cycle(input bit c, input bit v, input bit l, input bit r, input mvec_t vin);
    bit topen, mir, mov;
    mvec_t t;
    topen = (mdata.size() > 0) && !mclosed[mclosed.size()-1];
    mir   = topen || (mdata.size() < DEPTH);
    mov   = (mdata.size() > 0) && mclosed[0];
    chk("rnd_in_ready", int'(in_ready), int'(mir));
    chk("rnd_out_valid", int'(out_valid), int'(mov));
    chk("rnd_count", int'(count), mdata.size());
    chk("rnd_sat_flag", int'(sat_flag), int'(msat));
    if (mov && out_valid) begin
      for (int i = 0; i < CH; i++) chk("rnd_lane", lane(out_data, i), int'(mdata[0][i]));
    end
    if (c) begin
      mdata.delete(); mclosed.delete(); msat = 0;
      return;
    end
    if (v && mir) begin
      if (topen) begin
        t = mdata[mdata.size()-1];
        for (int i = 0; i < CH; i++) begin
          if (clamp(int'(t[i]) + int'(vin[i])) != int'(t[i]) + int'(vin[i])) msat = 1;
          t[i] = clamp(int'(t[i]) + int'(vin[i]));
        end
        mdata[mdata.size()-1] = t;
        mclosed[mclosed.size()-1] = l;
      end else begin
        mdata.push_back(vin);
        mclosed.push_back(l);
      end
    end
    if (mov && r) begin
      void'(mdata.pop_front());
      void'(mclosed.pop_front());
    end
  endtask

  vec_rec_t tbl[13];

  initial begin
    // c v l r  val      val9     cnt ov ir sat l0       l9
    tbl[0]  = '{0,1,1,1, 5,       -3,      1, 1, 1, 0, 5,       -3};
    tbl[1]  = '{0,0,0,1, 0,       0,       0, 0, 1, 0, 0,       0};
    tbl[2]  = '{0,1,0,1, 100,     100,     1, 0, 1, 0, 0,       0};
    tbl[3]  = '{0,1,0,1, 100,     100,     1, 0, 1, 0, 0,       0};
    tbl[4]  = '{0,1,1,1, 100,     100,     1, 1, 1, 0, 300,     300};
    tbl[5]  = '{0,0,0,1, 0,       0,       0, 0, 1, 0, 0,       0};
    tbl[6]  = '{0,1,0,1, 524000,  524000,  1, 0, 1, 0, 0,       0};
    tbl[7]  = '{0,1,1,1, 1000,    1000,    1, 1, 1, 1, 524287,  524287};
    tbl[8]  = '{0,0,0,1, 0,       0,       0, 0, 1, 1, 0,       0};
    tbl[9]  = '{0,1,0,1, -524288, -524288, 1, 0, 1, 1, 0,       0};
    tbl[10] = '{0,1,1,1, -1,      -1,      1, 1, 1, 1, -524288, -524288};
    tbl[11] = '{0,0,0,1, 0,       0,       0, 0, 1, 1, 0,       0};
    tbl[12] = '{1,0,0,0, 0,       0,       0, 0, 1, 0, 0,       0};

    rst = 1; idle();
    tick(); tick();
    rst = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_out_data_l0", lane(out_data, 0), 0);

    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].c, tbl[k].v, tbl[k].l, tbl[k].r, tbl[k].val, tbl[k].val9);
      tick();
      chk($sformatf("tbl%0d_count", k), int'(count), tbl[k].e_cnt);
      chk($sformatf("tbl%0d_out_valid", k), int'(out_valid), int'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_in_ready", k), int'(in_ready), int'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_sat_flag", k), int'(sat_flag), int'(tbl[k].e_sat));
      if (tbl[k].e_ov) begin
        chk($sformatf("tbl%0d_lane0", k), lane(out_data, 0), tbl[k].e_l0);
        chk($sformatf("tbl%0d_lane9", k), lane(out_data, CH-1), tbl[k].e_l9);
      end
    end

    // Full and backpressure: four closed entries, fifth write ignored, then drain.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 1, 0, k, k);
      tick();
    end
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    drive(0, 1, 1, 0, 99, 99);
    tick();
    chk("full_ignored_count", int'(count), 4);
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_out_valid", int'(out_valid), 1);
      chk("drain_lane0", lane(out_data, 0), k);
      tick();
    end
    chk("drain_count", int'(count), 0);

    // Steady push/pop at count 2 walking the pointers through several wraps.
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 1, 0, 10 + k, 10 + k);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 1, 1, 12 + k, 12 + k);
      chk("pp_lane0", lane(out_data, 0), 10 + k);
      tick();
      chk("pp_count", int'(count), 2);
    end
    drive(0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk("pp_drain_count", int'(count), 0);

    // Stable hold under backpressure: closed head with out_ready low.
    drive(0, 1, 1, 0, 33, 33);
    tick();
    idle();
    tick(); tick();
    chk("hold_lane0", lane(out_data, 0), 33);
    chk("hold_out_valid", int'(out_valid), 1);
    drive(0, 0, 0, 1, 0, 0);
    tick();

    // Soft clear mid-accumulation with a saturated closed entry ahead of the open tail.
    drive(0, 1, 0, 0, LMAX, LMAX); tick();
    drive(0, 1, 1, 0, 1, 1);       tick();
    drive(0, 1, 1, 0, 21, 21);     tick();
    drive(0, 1, 0, 0, 50, 50);     tick();
    chk("clr_pre_count", int'(count), 3);
    chk("clr_pre_sat", int'(sat_flag), 1);
    drive(1, 1, 1, 1, 999, 999);
    tick();
    chk("clr_count", int'(count), 0);
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_sat_flag", int'(sat_flag), 0);
    chk("clr_in_ready", int'(in_ready), 1);
    drive(0, 1, 1, 1, 7, 7);
    tick();
    chk("clr_post_out_valid", int'(out_valid), 1);
    chk("clr_post_lane0", lane(out_data, 0), 7);
    idle(); out_ready = 1;
    tick();
    chk("clr_post_count", int'(count), 0);

    // Randomized traffic vs. the queue model, starting from a clean reset.
    rst = 1; idle(); tick(); rst = 0;
    mdata.delete(); mclosed.delete(); msat = 0;
    for (int n = 0; n < 3000; n++) begin
      bit c, v, l, r;
      mvec_t vin;
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 70);
      l = ($urandom_range(0, 99) < 40);
      r = ($urandom_range(0, 99) < 55);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) vin[i] = lane_t'($urandom_range(0, (1 << DW) - 1)) + LMIN;
        else vin[i] = lane_t'($urandom_range(0, 200)) - 100;
      end
      clr = c; in_valid = v; in_last = l; out_ready = r;
      for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = vin[i][DW-1:0];
      model_cycle(c, v, l, r, vin);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
